// File: rtl/audio_meter_pkg.sv
// audio_meter_pkg: shared state encoding and default sizing for the PWM tone meter.
package audio_meter_pkg;
    typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} meter_state_e;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 100_000_000;
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: 2-flop synchronizer, optional glitch filter (PWM_TONE_METER_GLITCH_FILTER_EN) and registered rise/fall detector.
module pwm_edge_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, prev_q, rise_q, fall_q, lvl;
`ifdef PWM_TONE_METER_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    // The filtered level only follows s2_q once it has disagreed for FILT_LEN cycles in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = s2_q;
            else fcnt_d = fcnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end
    assign lvl = filt_q;
`else
    localparam int unused_filt_len = FILT_LEN;
    assign lvl = s2_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= pwm_i;
            s2_q   <= s1_q;
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/pwm_tone_meter.sv
// pwm_tone_meter: measures period/high time of an async PWM input with lock and no-signal reporting.
// Optional input glitch filter enabled by PWM_TONE_METER_GLITCH_FILTER_EN.
module pwm_tone_meter
    import audio_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int LOCK_TOL = 4,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             no_signal
);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
    logic [CNT_W-1:0] idle_q, idle_d, cnt_inc, diff;
    logic             valid_q, valid_d, nosig_q, nosig_d, have_prev_q, have_prev_d;
    logic [1:0]       stab_q, stab_d;
    logic             rise, fall, any_edge, timeout, close;
    pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_i (pwm_in),
        .rise_o(rise),
        .fall_o(fall)
    );
    assign any_edge = rise | fall;
    assign timeout  = !any_edge && idle_q == TO_M1;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign diff     = cnt_q >= period_q ? cnt_q - period_q : period_q - cnt_q;
    assign close    = diff <= CNT_W'(LOCK_TOL);
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        have_prev_d = have_prev_q;
        stab_d      = stab_q;
        idle_d      = any_edge ? '0 : (idle_q == TO_M1 ? idle_q : idle_q + 1'b1);
        nosig_d     = any_edge ? 1'b0 : (timeout ? 1'b1 : nosig_q);
        if (timeout) begin
            state_d     = WAIT_RISE;
            cnt_d       = '0;
            stab_d      = '0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_RISE: begin
                    cnt_d   = rise ? CNT_W'(1) : '0;
                    state_d = rise ? MEAS_HIGH : WAIT_RISE;
                end
                MEAS_HIGH: begin
                    cnt_d   = cnt_inc;
                    hi_d    = fall ? cnt_q : hi_q;
                    state_d = fall ? MEAS_LOW : MEAS_HIGH;
                end
                MEAS_LOW: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        period_d    = cnt_q;
                        high_d      = hi_q;
                        valid_d     = 1'b1;
                        cnt_d       = CNT_W'(1);
                        state_d     = MEAS_HIGH;
                        have_prev_d = 1'b1;
                        // period_q still holds the previous period when compared here
                        stab_d      = (have_prev_q && close) ? (stab_q == 2'd3 ? stab_q : stab_q + 2'd1) : 2'd0;
                    end
                end
                default: state_d = WAIT_RISE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_RISE;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            have_prev_q <= 1'b0;
            stab_q      <= '0;
            idle_q      <= '0;
            nosig_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            have_prev_q <= have_prev_d;
            stab_q      <= stab_d;
            idle_q      <= idle_d;
            nosig_q     <= nosig_d;
        end
    end
    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = stab_q != 2'd0;
    assign no_signal = nosig_q;
endmodule

// File: tb/tb_pwm_tone_meter.sv
// tb_pwm_tone_meter: table-driven waveform stimulus with a scoreboard of expected valid reports.
module tb_pwm_tone_meter;
    localparam int TO = 5000;
    localparam int FL = 3;
`ifdef PWM_TONE_METER_GLITCH_FILTER_EN
    localparam int LAG = 4 + FL;
`else
    localparam int LAG = 4;
`endif
    localparam int N = 20;
    logic        clk = 1'b0, rst = 1'b1, pwm_in = 1'b0;
    logic [31:0] period, high_time;
    logic        valid, locked, no_signal;
    typedef struct {int per; int hi; bit lk;} vec_t;
    vec_t tab [N];
    vec_t exp_q[$];
    int   pass_n = 0, total_n = 0;

    pwm_tone_meter #(.CNT_W(32), .TIMEOUT(TO), .LOCK_TOL(4), .FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
        .valid(valid), .locked(locked), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        total_n++;
        if (act == req) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int per, input int hi, input bit lk);
        vec_t v;
        v.per = per; v.hi = hi; v.lk = lk;
        return v;
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (valid !== 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("period", period, e.per);
                chk("high_time", high_time, e.hi);
                chk("locked_at_valid", locked, e.lk);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) tab[i] = mk(1000, 500, i > 0);
        for (int i = 5; i < 9; i++) tab[i] = mk(400, 100, i > 5);
        tab[9]  = mk(600, 150, 0);
        tab[10] = mk(600, 150, 1);
        tab[11] = mk(1000, 500, 0);
        tab[12] = mk(1003, 501, 1);
        tab[13] = mk(1000, 500, 1);
        tab[14] = mk(998, 499, 1);
        tab[15] = mk(1001, 500, 1);
        tab[16] = mk(1010, 505, 0);
        tab[17] = mk(1000, 500, 0);
        tab[18] = mk(1000, 500, 1);
        tab[19] = mk(1000, 500, 1);

        wait_cyc(3);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_no_signal", no_signal, 1);
        rst = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < N; i++) begin
            if (i > 0) exp_q.push_back(tab[i-1]);
            pwm_in = 1'b1;
            wait_cyc(tab[i].hi);
            if (i == 0) chk("no_signal_after_edge", no_signal, 0);
            pwm_in = 1'b0;
            wait_cyc(tab[i].per - tab[i].hi);
        end

        exp_q.push_back(tab[N-1]);
        pwm_in = 1'b1;
        wait_cyc(500);
        pwm_in = 1'b0;
        wait_cyc(TO + LAG - 1);
        chk("no_signal_before_timeout", no_signal, 0);
        chk("locked_before_timeout", locked, 1);
        wait_cyc(1);
        chk("no_signal_at_timeout", no_signal, 1);
        chk("locked_at_timeout", locked, 0);
        chk("period_hold", period, 1000);
        chk("high_hold", high_time, 500);
        chk("queue_drained_timeout", exp_q.size(), 0);

        pwm_in = 1'b1;
        wait_cyc(500);
        pwm_in = 1'b0;
        wait_cyc(300);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("midrst_period", period, 0);
        chk("midrst_high_time", high_time, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_no_signal", no_signal, 1);
        wait_cyc(50);

        pwm_in = 1'b1;
        wait_cyc(200);
        chk("no_signal_after_rst_edge", no_signal, 0);
        pwm_in = 1'b0;
        wait_cyc(600);
        exp_q.push_back(mk(800, 200, 0));
        pwm_in = 1'b1;
        wait_cyc(500);
        pwm_in = 1'b0;
        wait_cyc(500);
        exp_q.push_back(mk(1000, 500, 0));
        pwm_in = 1'b1;
        wait_cyc(500);
        pwm_in = 1'b0;
        wait_cyc(250);
`ifndef PWM_TONE_METER_GLITCH_FILTER_EN
        exp_q.push_back(mk(750, 500, 0));
`endif
        pwm_in = 1'b1;
        wait_cyc(1);
        pwm_in = 1'b0;
        wait_cyc(249);
`ifdef PWM_TONE_METER_GLITCH_FILTER_EN
        exp_q.push_back(mk(1000, 500, 1));
`else
        exp_q.push_back(mk(250, 1, 0));
`endif
        pwm_in = 1'b1;
        wait_cyc(500);
        pwm_in = 1'b0;
        wait_cyc(20);
        chk("queue_drained_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/pwm_tone_meter.md
Name: pwm_tone_meter

Overview:
- Receive-side counterpart of the PWM tone generator path: samples an external square/PWM input and measures its period and high time in clk cycles.
- Reports each completed period with a one-cycle valid strobe, a lock indication for a stable tone and a no-signal flag.
- Used for loopback self-test of the audio PWM output and for detecting tones from an external source on a PMOD pin.

Parameters:
- CNT_W, 32, width of the period/high-time counters and outputs.
- TIMEOUT, 100_000_000, cycles without an edge before no_signal is raised (1 s at 100 MHz).
- LOCK_TOL, 4, maximum absolute difference in cycles between consecutive periods that still counts as stable.
- FILT_LEN, 3, glitch-filter stability length in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM/square input.
- period  output  CNT_W  last measured period in clk cycles.
- high_time  output  CNT_W  last measured high time in clk cycles.
- valid  output  1  one-cycle strobe when period/high_time update.
- locked  output  1  high while consecutive periods agree within LOCK_TOL.
- no_signal  output  1  high after TIMEOUT cycles with no detected edge.

Behaviour:
- Reset values:
  - period, high_time = 0.
  - valid, locked = 0.
  - no_signal = 1.
  - FSM in WAIT_RISE with counter = 0.
- Front end:
  - 2-flop synchronizer, then a registered edge detector.
  - Detected rise/fall lags the pwm_in transition by 3 clk cycles. The fixed lag cancels out in the measured values.
- FSM:
  - WAIT_RISE: counter cleared. On rise: go to MEAS_HIGH and set counter = 1.
  - MEAS_HIGH: counter increments each cycle. On fall: latch hi_cnt = counter, go to MEAS_LOW, keep counting.
  - MEAS_LOW: counter increments each cycle. On rise, in that same cycle:
    - register period = counter and high_time = hi_cnt;
    - pulse valid for exactly 1 cycle;
    - reload counter = 1 and go to MEAS_HIGH.
  - For clean input, period equals the exact clk-cycle period. valid fires once per input period, starting from the second detected rise.
- Timeout:
  - A free-running idle counter resets on every detected edge.
  - When it reaches TIMEOUT: no_signal = 1, locked = 0, FSM goes to WAIT_RISE.
  - period and high_time hold their last values.
  - no_signal clears on the cycle of the next detected edge.
- Saturation: counters saturate at all-ones and never wrap. Timeout fires first whenever TIMEOUT < 2^CNT_W.
- Lock:
  - On each valid, compare the new period against the previous one.
  - If |diff| ≤ LOCK_TOL, increment a 2-bit stable count (saturating). Otherwise clear it.
  - locked = (stable count ≥ 1). Net effect: locked rises on the second consecutive matching valid.
  - The first valid after reset or timeout has no previous period and never sets locked.
- Simultaneous events:
  - A rise coinciding with timeout: the edge wins. Idle counter is cleared and no_signal stays or goes low.
  - Rise and fall cannot occur in the same cycle.
- Reset mid-measurement: everything returns to reset values. The first valid after reset needs a full new rise-to-rise period.

Optional Feature:
- Macro PWM_TONE_METER_GLITCH_FILTER_EN.
- Defined: the synchronized input must hold a new level for FILT_LEN consecutive cycles before the filtered level changes.
  - Pulses shorter than FILT_LEN are ignored.
  - Edge latency grows by FILT_LEN cycles. Measured values are unchanged for clean input.
- Undefined: no filter; any synchronized transition is an edge.

Decomposition:
- Package audio_meter_pkg holds:
  - state enum (WAIT_RISE, MEAS_HIGH, MEAS_LOW);
  - default CNT_W and TIMEOUT constants.
- Sub-module pwm_edge_sync holds the synchronizer, the optional glitch filter and the rise/fall detector. The FSM, counters and lock logic stay in the top.

Test Plan:
- 50% square wave, period 1000 cycles, for 5 periods:
  - valid every 1000 cycles with period=1000 and high_time=500;
  - locked=1 from the 2nd valid; no_signal=0 after the first edge.
- 25% duty, period 400:
  - period=400 and high_time=100 on every valid;
  - switching to period 600 drops locked on that valid and relocks on the next.
- Input stuck low after 3 periods, with TIMEOUT=5000:
  - no_signal=1 and locked=0 exactly 5000 cycles after the last edge;
  - period holds 1000; no valid pulses.
- rst asserted mid-MEAS_LOW:
  - outputs reset next cycle;
  - first valid only after two further rises, with the correct period.
- Jittered periods 1000/1003/998 (LOCK_TOL=4):
  - locked from the 2nd valid;
  - a 1010 period clears locked.
- With PWM_TONE_METER_GLITCH_FILTER_EN and FILT_LEN=3:
  - a 1-cycle high glitch inside the low phase leaves period=1000 unchanged;
  - without the macro, the same glitch produces a short-period valid.
